xpt_step_sequencer: RTL and testbench

- Instruction step (XPT) sequencer that drives the XPT/notXPT buses read by every DECODER_I_* block.
- Consumes the end-of-instruction pulses those decoders emit: PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, Pa_Ophd.
- Owns the opcode-fetch (M1) flag, the instruction-table select, the opcode latch and the operand-hold flag.
- Sits between the bus interface and the decoder array.

---
 rtl/xpt_step_sequencer_if.sv | 53 +++++
 rtl/xpt_step_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_xpt_step_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/xpt_step_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : xpt_step_sequencer_if
// Description : Bundle of the XPT sequencer signals.
//               The bus interface and the decoder array use the master side.
//               The sequencer itself uses the slave side.
//               Inputs to the sequencer:
//                 WAIT, DATA_IN, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE,
//                 P_Set_ITABLE, ITABLE_IN, Pa_Ophd
//               Outputs from the sequencer:
//                 XPT, notXPT, CM1, ITABLE, OPCODE, OPHD, XPT_OVF
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface xpt_step_sequencer_if #(
  parameter int STEP_W = 4,
  parameter int TBL_W  = 2
);
  // Bus side and decoder pulses, all sampled on the rising clock edge.
  logic              WAIT;
  logic [7:0]        DATA_IN;
  logic              PR_Reset_XPT;
  logic              P2_Set_CM1;
  logic              P2_Reset_ITABLE;
  logic              P_Set_ITABLE;
  logic [TBL_W-1:0]  ITABLE_IN;
  logic              Pa_Ophd;

  // Registered sequencer state, fanned out to every decoder.
  logic [STEP_W-1:0] XPT;
  logic [STEP_W-1:0] notXPT;
  logic              CM1;
  logic [TBL_W-1:0]  ITABLE;
  logic [7:0]        OPCODE;
  logic              OPHD;
  logic              XPT_OVF;

  // Bus interface / decoder array side.
  modport master (
    output WAIT, DATA_IN, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE,
           P_Set_ITABLE, ITABLE_IN, Pa_Ophd,
    input  XPT, notXPT, CM1, ITABLE, OPCODE, OPHD, XPT_OVF
  );

  // Sequencer side.
  modport slave (
    input  WAIT, DATA_IN, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE,
           P_Set_ITABLE, ITABLE_IN, Pa_Ophd,
    output XPT, notXPT, CM1, ITABLE, OPCODE, OPHD, XPT_OVF
  );
endinterface

`default_nettype wire

// File: rtl/xpt_step_sequencer.sv
//------------------------------------------------------------------------------
// Module      : xpt_step_sequencer
// Description : Instruction step (XPT) sequencer.
//               It drives XPT/notXPT to the decoder array.
//               It consumes the end-of-instruction pulses from the decoders.
//               It owns the opcode-fetch flag (CM1), the instruction table
//               select, the opcode latch and the operand-hold flag.
// Ports       : CLK    - system clock, rising edge
//               RESET  - asynchronous, active-high reset
//               bus    - xpt_step_sequencer_if.slave
//                          inputs : WAIT, DATA_IN, decoder pulses, ITABLE_IN
//                          outputs: XPT, notXPT, CM1, ITABLE, OPCODE,
//                                   OPHD, XPT_OVF
//               Every output is a flop.
//               There is no combinational path from an input to an output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xpt_step_sequencer #(
  parameter int STEP_W      = 4,
  parameter int FETCH_STEPS = 3,
  parameter int TBL_W       = 2
) (
  input  wire                  CLK,
  input  wire                  RESET,
  xpt_step_sequencer_if.slave  bus
);

  // Step on whose exit the opcode is latched and CM1 drops.
  localparam logic [STEP_W-1:0] c_last_fetch = STEP_W'(FETCH_STEPS - 1);
  localparam logic [STEP_W-1:0] c_step_max   = {STEP_W{1'b1}};

  // Registered state.
  logic [STEP_W-1:0] r_xpt;
  logic [STEP_W-1:0] r_not_xpt;
  logic              r_cm1;
  logic [TBL_W-1:0]  r_itable;
  logic [7:0]        r_opcode;
  logic              r_ophd;
  logic              r_xpt_ovf;

  // Next-state values.
  logic [STEP_W-1:0] w_xpt_nxt;
  logic              w_cm1_nxt;
  logic [TBL_W-1:0]  w_itable_nxt;
  logic [7:0]        w_opcode_nxt;
  logic              w_ophd_nxt;
  logic              w_xpt_ovf_nxt;

  // Step qualifiers.
  logic              w_at_max;
  logic              w_advance;
  logic              w_fetch_done;
  logic              w_opcode_load;

  //----------------------------------------------------------------------------
  // Step qualifiers.
  // w_advance means XPT really increments on this edge.
  // It is false when a PR_Reset_XPT, a WAIT or saturation blocks the increment.
  //----------------------------------------------------------------------------
  assign w_at_max      = (r_xpt == c_step_max);
  assign w_advance     = !bus.PR_Reset_XPT && !bus.WAIT && !w_at_max;
  assign w_fetch_done  = w_advance && (r_xpt == c_last_fetch);

  // The opcode is latched at the end of the last fetch step.
  // This only happens in a real fetch cycle that is not stalled by WAIT.
  assign w_opcode_load = r_cm1 && !bus.WAIT && (r_xpt == c_last_fetch);

  //----------------------------------------------------------------------------
  // Step counter.
  // Priority: PR_Reset_XPT first, then WAIT, then saturation, then increment.
  // Overflow is flagged only when an increment was due but blocked at the top.
  // A WAIT at the top or a PR_Reset_XPT does not flag overflow.
  //----------------------------------------------------------------------------
  always_comb begin
    w_xpt_nxt     = r_xpt;
    w_xpt_ovf_nxt = r_xpt_ovf;
    if (bus.PR_Reset_XPT) begin
      w_xpt_nxt = '0;
    end else if (bus.WAIT) begin
      w_xpt_nxt = r_xpt;
    end else if (w_at_max) begin
      w_xpt_nxt     = r_xpt;
      w_xpt_ovf_nxt = 1'b1;
    end else begin
      w_xpt_nxt = r_xpt + 1'b1;
    end
  end

  //----------------------------------------------------------------------------
  // CM1 (opcode-fetch flag).
  // P2_Set_CM1 arms the next instruction's fetch.
  // It is honoured even without an accompanying PR_Reset_XPT.
  // CM1 drops when the counter really moves from the last fetch step.
  // WAIT holds it, because a stalled step never advances.
  //----------------------------------------------------------------------------
  always_comb begin
    w_cm1_nxt = r_cm1;
    if (bus.P2_Set_CM1) begin
      w_cm1_nxt = 1'b1;
    end else if (w_fetch_done) begin
      w_cm1_nxt = 1'b0;
    end
  end

  //----------------------------------------------------------------------------
  // Opcode latch.
  //----------------------------------------------------------------------------
  always_comb begin
    w_opcode_nxt = r_opcode;
    if (w_opcode_load) begin
      w_opcode_nxt = bus.DATA_IN;
    end
  end

  //----------------------------------------------------------------------------
  // Instruction table select.
  // A prefix load beats a return-to-main request.
  // This lets chained prefixes keep the table the newest prefix selected.
  //----------------------------------------------------------------------------
  always_comb begin
    w_itable_nxt = r_itable;
    if (bus.P_Set_ITABLE) begin
      w_itable_nxt = bus.ITABLE_IN;
    end else if (bus.P2_Reset_ITABLE) begin
      w_itable_nxt = '0;
    end
  end

  //----------------------------------------------------------------------------
  // Operand-hold flag.
  // It is set by the decoder and cleared when the next opcode is latched.
  // The set wins when both happen on the same edge, so a hold request is
  // never lost.
  //----------------------------------------------------------------------------
  always_comb begin
    w_ophd_nxt = r_ophd;
    if (bus.Pa_Ophd) begin
      w_ophd_nxt = 1'b1;
    end else if (w_opcode_load) begin
      w_ophd_nxt = 1'b0;
    end
  end

  //----------------------------------------------------------------------------
  // State registers.
  // notXPT is loaded from the same next-state value as XPT, in the same flop
  // stage. The two buses therefore never disagree, even for one cycle.
  //----------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_xpt     <= '0;
      r_not_xpt <= '1;
      r_cm1     <= 1'b1;
      r_itable  <= '0;
      r_opcode  <= 8'h00;
      r_ophd    <= 1'b0;
      r_xpt_ovf <= 1'b0;
    end else begin
      r_xpt     <= w_xpt_nxt;
      r_not_xpt <= ~w_xpt_nxt;
      r_cm1     <= w_cm1_nxt;
      r_itable  <= w_itable_nxt;
      r_opcode  <= w_opcode_nxt;
      r_ophd    <= w_ophd_nxt;
      r_xpt_ovf <= w_xpt_ovf_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // Outputs.
  //----------------------------------------------------------------------------
  assign bus.XPT     = r_xpt;
  assign bus.notXPT  = r_not_xpt;
  assign bus.CM1     = r_cm1;
  assign bus.ITABLE  = r_itable;
  assign bus.OPCODE  = r_opcode;
  assign bus.OPHD    = r_ophd;
  assign bus.XPT_OVF = r_xpt_ovf;

endmodule

`default_nettype wire

// File: tb/tb_xpt_step_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_xpt_step_sequencer
// Description : Directed, table-driven bench for xpt_step_sequencer.
//               Each table row holds one cycle of inputs and the outputs
//               expected after the following rising edge.
//               Hand-written sequences follow for the asynchronous reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xpt_step_sequencer;

  localparam int STEP_W      = 4;
  localparam int FETCH_STEPS = 3;
  localparam int TBL_W       = 2;

  typedef struct {
    // Inputs.
    logic              wt;
    logic [7:0]        din;
    logic              pr;
    logic              scm;
    logic              rit;
    logic              sit;
    logic [TBL_W-1:0]  itin;
    logic              pah;
    // Expected outputs after the edge.
    logic [STEP_W-1:0] xpt;
    logic              cm1;
    logic [TBL_W-1:0]  it;
    logic [7:0]        op;
    logic              ophd;
    logic              ovf;
  } vec_t;

  logic CLK;
  logic RESET;
  int   tests;
  int   fails;

  vec_t vecs[64];
  int   nvec;

  xpt_step_sequencer_if #(.STEP_W(STEP_W), .TBL_W(TBL_W)) bus ();

  xpt_step_sequencer #(
    .STEP_W      (STEP_W),
    .FETCH_STEPS (FETCH_STEPS),
    .TBL_W       (TBL_W)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Append one row to the vector table.
  task automatic add(input logic wt, input logic [7:0] din, input logic pr,
                     input logic scm, input logic rit, input logic sit,
                     input logic [TBL_W-1:0] itin, input logic pah,
                     input logic [STEP_W-1:0] xpt, input logic cm1,
                     input logic [TBL_W-1:0] it, input logic [7:0] op,
                     input logic ophd, input logic ovf);
    vecs[nvec].wt   = wt;   vecs[nvec].din  = din;  vecs[nvec].pr  = pr;
    vecs[nvec].scm  = scm;  vecs[nvec].rit  = rit;  vecs[nvec].sit = sit;
    vecs[nvec].itin = itin; vecs[nvec].pah  = pah;
    vecs[nvec].xpt  = xpt;  vecs[nvec].cm1  = cm1;  vecs[nvec].it  = it;
    vecs[nvec].op   = op;   vecs[nvec].ophd = ophd; vecs[nvec].ovf = ovf;
    nvec++;
  endtask

  task automatic drive(input logic wt, input logic [7:0] din, input logic pr,
                       input logic scm, input logic rit, input logic sit,
                       input logic [TBL_W-1:0] itin, input logic pah);
    bus.WAIT            = wt;
    bus.DATA_IN         = din;
    bus.PR_Reset_XPT    = pr;
    bus.P2_Set_CM1      = scm;
    bus.P2_Reset_ITABLE = rit;
    bus.P_Set_ITABLE    = sit;
    bus.ITABLE_IN       = itin;
    bus.Pa_Ophd         = pah;
  endtask

  // Compare every output against an expected state.
  // notXPT is expected as the inverse of the expected XPT.
  task automatic check(input string name, input logic [STEP_W-1:0] xpt,
                       input logic cm1, input logic [TBL_W-1:0] it,
                       input logic [7:0] op, input logic ophd, input logic ovf);
    logic [STEP_W-1:0] nx;
    nx = ~xpt;
    tests++;
    if (bus.XPT !== xpt || bus.notXPT !== nx || bus.CM1 !== cm1 ||
        bus.ITABLE !== it || bus.OPCODE !== op || bus.OPHD !== ophd ||
        bus.XPT_OVF !== ovf) begin
      fails++;
      $display("FAIL %s: got XPT=%h notXPT=%h CM1=%b IT=%h OP=%h OPHD=%b OVF=%b, want XPT=%h notXPT=%h CM1=%b IT=%h OP=%h OPHD=%b OVF=%b",
               name, bus.XPT, bus.notXPT, bus.CM1, bus.ITABLE, bus.OPCODE,
               bus.OPHD, bus.XPT_OVF, xpt, nx, cm1, it, op, ophd, ovf);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nvec  = 0;

    // Vector table: wt din pr scm rit sit itin pah | xpt cm1 it op ophd ovf.
    // Power-up fetch: CM1 for steps 0..2, and the opcode latches on the 2->3 edge.
    add(0, 8'h36, 0,0,0,0, 2'd0, 0,   4'd1, 1, 2'd0, 8'h00, 0, 0);
    add(0, 8'h36, 0,0,0,0, 2'd0, 0,   4'd2, 1, 2'd0, 8'h00, 0, 0);
    add(0, 8'h36, 0,0,0,0, 2'd0, 0,   4'd3, 0, 2'd0, 8'h36, 0, 0);
    add(0, 8'h36, 0,0,0,1, 2'd1, 0,   4'd4, 0, 2'd1, 8'h36, 0, 0);
    add(0, 8'h36, 0,0,0,0, 2'd0, 0,   4'd5, 0, 2'd1, 8'h36, 0, 0);
    // End of instruction: all four decoder pulses together.
    add(0, 8'h36, 1,1,1,0, 2'd0, 1,   4'd0, 1, 2'd0, 8'h36, 1, 0);
    add(0, 8'h5A, 0,0,0,0, 2'd0, 0,   4'd1, 1, 2'd0, 8'h36, 1, 0);
    add(0, 8'h5A, 0,0,0,0, 2'd0, 0,   4'd2, 1, 2'd0, 8'h36, 1, 0);
    // WAIT for three cycles at the last fetch step.
    add(1, 8'h77, 0,0,0,0, 2'd0, 0,   4'd2, 1, 2'd0, 8'h36, 1, 0);
    add(1, 8'h77, 0,0,0,0, 2'd0, 0,   4'd2, 1, 2'd0, 8'h36, 1, 0);
    add(1, 8'h77, 0,0,0,0, 2'd0, 0,   4'd2, 1, 2'd0, 8'h36, 1, 0);
    add(0, 8'hA5, 0,0,0,0, 2'd0, 0,   4'd3, 0, 2'd0, 8'hA5, 0, 0);
    // Free-running run up to saturation.
    for (int s = 4; s <= 15; s++)
      add(0, 8'hA5, 0,0,0,0, 2'd0, 0, 4'(s), 0, 2'd0, 8'hA5, 0, 0);
    add(0, 8'hA5, 0,0,0,0, 2'd0, 0,   4'd15, 0, 2'd0, 8'hA5, 0, 1);
    add(1, 8'hA5, 0,0,0,0, 2'd0, 0,   4'd15, 0, 2'd0, 8'hA5, 0, 1);
    // PR_Reset_XPT alone: XPT=0, OVF is sticky, CM1 stays low, no opcode latch.
    add(0, 8'hA5, 1,0,0,0, 2'd0, 0,   4'd0, 0, 2'd0, 8'hA5, 0, 1);
    add(0, 8'hA5, 0,0,0,0, 2'd0, 0,   4'd1, 0, 2'd0, 8'hA5, 0, 1);
    add(0, 8'hA5, 0,0,0,0, 2'd0, 0,   4'd2, 0, 2'd0, 8'hA5, 0, 1);
    add(0, 8'h11, 0,0,0,0, 2'd0, 0,   4'd3, 0, 2'd0, 8'hA5, 0, 1);
    // Table select: a set beats a simultaneous reset; a lone reset returns to 0.
    add(0, 8'h11, 0,0,1,1, 2'd2, 0,   4'd4, 0, 2'd2, 8'hA5, 0, 1);
    add(0, 8'h11, 0,0,0,0, 2'd0, 0,   4'd5, 0, 2'd2, 8'hA5, 0, 1);
    add(0, 8'h11, 0,0,1,0, 2'd0, 0,   4'd6, 0, 2'd0, 8'hA5, 0, 1);
    // P2_Set_CM1 without PR_Reset_XPT still sets CM1.
    add(0, 8'h11, 0,1,0,0, 2'd0, 0,   4'd7, 1, 2'd0, 8'hA5, 0, 1);
    add(0, 8'h11, 0,0,0,0, 2'd0, 0,   4'd8, 1, 2'd0, 8'hA5, 0, 1);
    // New fetch: Pa_Ophd on the opcode-latch edge, so OPHD is set.
    add(0, 8'h11, 1,1,0,0, 2'd0, 0,   4'd0, 1, 2'd0, 8'hA5, 0, 1);
    add(0, 8'h11, 0,0,0,0, 2'd0, 0,   4'd1, 1, 2'd0, 8'hA5, 0, 1);
    add(0, 8'h11, 0,0,0,0, 2'd0, 0,   4'd2, 1, 2'd0, 8'hA5, 0, 1);
    add(0, 8'h3C, 0,0,0,0, 2'd0, 1,   4'd3, 0, 2'd0, 8'h3C, 1, 1);

    // Reset state.
    drive(0, 8'h00, 0,0,0,0, 2'd0, 0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset", 4'd0, 1, 2'd0, 8'h00, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;

    // Table-driven run.
    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].wt, vecs[i].din, vecs[i].pr, vecs[i].scm, vecs[i].rit,
            vecs[i].sit, vecs[i].itin, vecs[i].pah);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d", i), vecs[i].xpt, vecs[i].cm1, vecs[i].it,
            vecs[i].op, vecs[i].ophd, vecs[i].ovf);
    end

    // Move to XPT=7 with ITABLE=1 and OPHD=1 (currently XPT=3, OPHD=1).
    drive(0, 8'h3C, 0,0,0,1, 2'd1, 0);
    @(posedge CLK); #1;
    drive(0, 8'h3C, 0,0,0,0, 2'd0, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("pre_async", 4'd7, 0, 2'd1, 8'h3C, 1, 1);

    // Asynchronous reset in the middle of the cycle, checked before the next edge.
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset", 4'd0, 1, 2'd0, 8'h00, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("post_reset_step", 4'd1, 1, 2'd0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
